// File: rtl/arbiter_pkg.sv
// Shared arbiter definitions: FSM state encoding and the find-first-set helper
// used by the round-robin pick logic.
package arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int FF1_MAX_W = 64;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int ff1(input logic [FF1_MAX_W-1:0] v);
        int r;
        r = 0;
        for (int i = FF1_MAX_W - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after the pointer,
// falling back to the lowest requester when nothing lies above it.
module arbiter_rr_pick
    import arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = 6,
    localparam int SEL_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] request,
    input  logic [SEL_WIDTH-1:0] pointer,
    output logic [NUM_PORTS-1:0] pick,
    output logic [SEL_WIDTH-1:0] index,
    output logic                 any
);

    logic [NUM_PORTS-1:0] mask;
    logic [NUM_PORTS-1:0] masked;
    logic [FF1_MAX_W-1:0] vec;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_mask
        assign mask[i] = (i >= int'(pointer));
    end

    assign masked = request & mask;
    assign any    = |request;

    always_comb begin
        vec                = '0;
        vec[NUM_PORTS-1:0] = (|masked) ? masked : request;
    end

    assign index = SEL_WIDTH'(ff1(vec));
    assign pick  = any ? (NUM_PORTS'(1) << index) : '0;

endmodule

// File: rtl/arbiter_burst_ctrl.sv
// Burst-locked round-robin controller: the winner holds the shared port until
// its declared beat count completes or the no-progress watchdog fires.
module arbiter_burst_ctrl
    import arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = 6,
    parameter  int LEN_WIDTH = 8,
    parameter  int TIMEOUT   = 255,
    localparam int SEL_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           request,
    input  logic [NUM_PORTS*LEN_WIDTH-1:0] len,
    input  logic                           beat,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [SEL_WIDTH-1:0]           select,
    output logic                           active,
    output logic                           done,
    output logic                           timeout
);

    localparam int WD_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t               state;
    logic [SEL_WIDTH-1:0] pointer;
    logic [SEL_WIDTH-1:0] pick_idx;
    logic [SEL_WIDTH-1:0] next_ptr;
    logic [NUM_PORTS-1:0] pick;
    logic                 pick_any;
    logic [LEN_WIDTH-1:0] pick_len;
    logic [LEN_WIDTH-1:0] remaining;
    logic [WD_WIDTH-1:0]  wd;
    logic                 last_beat;
    logic                 wd_expire;

    arbiter_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .request (request),
        .pointer (pointer),
        .pick    (pick),
        .index   (pick_idx),
        .any     (pick_any)
    );

    assign pick_len  = len[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
    assign next_ptr  = (select == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : select + 1'b1;
    assign last_beat = (state == BUSY) && beat && (remaining == '0);
    // A beat always clears the watchdog, so a final beat can never lose to expiry.
    assign wd_expire = (TIMEOUT > 0) && (state == BUSY) && !beat &&
                       (int'(wd) == TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            select    <= '0;
            active    <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            pointer   <= '0;
            remaining <= '0;
            wd        <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= BUSY;
                        grant     <= pick;
                        select    <= pick_idx;
                        active    <= 1'b1;
                        remaining <= pick_len;
                        wd        <= '0;
                    end
                end
                BUSY: begin
                    if (last_beat || wd_expire) begin
                        state     <= IDLE;
                        grant     <= '0;
                        select    <= '0;
                        active    <= 1'b0;
                        done      <= last_beat;
                        timeout   <= !last_beat;
                        pointer   <= next_ptr;
                        remaining <= '0;
                        wd        <= '0;
                    end else if (beat) begin
                        remaining <= remaining - 1'b1;
                        wd        <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_burst_ctrl.sv
// Self-checking bench for arbiter_burst_ctrl: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_arbiter_burst_ctrl;

    localparam int N  = 6;
    localparam int LW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  request = '0;
    logic [N*LW-1:0] len = '0;
    logic          beat = 1'b0;
    logic [N-1:0]  grant;
    logic [2:0]    select;
    logic          active;
    logic          done;
    logic          timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: owner port (-1 when idle), beats still owed, idle beat run
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_left  = 0;
    int   m_idle  = 0;
    logic m_done  = 1'b0;
    logic m_to    = 1'b0;

    arbiter_burst_ctrl #(.NUM_PORTS(N), .LEN_WIDTH(LW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .request (request),
        .len     (len),
        .beat    (beat),
        .grant   (grant),
        .select  (select),
        .active  (active),
        .done    (done),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit found;
        m_done = 1'b0;
        m_to   = 1'b0;
        if (!rst) begin
            m_owner = -1; m_ptr = 0; m_left = 0; m_idle = 0;
        end else if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (!found && request[p]) begin
                    found = 1; m_owner = p; m_idle = 0;
                    m_left = int'(len[p*LW +: LW]) + 1;
                end
            end
        end else begin
            if (beat) begin
                m_left--; m_idle = 0;
                if (m_left == 0) m_done = 1'b1;
            end else begin
                m_idle++;
                if (m_idle == TO) m_to = 1'b1;
            end
            if (m_done || m_to) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; request = '0; beat = 1'b0; len = '0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; request = 6'h3F; beat = 1'b0; len = '0;
        tick(); tick(); tick();
        n_cmp++;
        if ({grant, select, active, done, timeout} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got grant=%h sel=%0d act=%b done=%b to=%b want all 0",
                     grant, select, active, done, timeout);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (grant !== 6'h01 || select !== 3'd0 || active !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_grant got grant=%h sel=%0d act=%b want 01/0/1", grant, select, active);
        end
    endtask

    task automatic test_burst_lock();
        do_reset();
        request = 6'h04; len[2*LW +: LW] = 8'd3; beat = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 6'h04 || select !== 3'd2) begin
            n_bad++;
            $display("FAIL lock_grant got grant=%h sel=%0d want 04/2", grant, select);
        end
        beat = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            if (b == 2) begin request = 6'h09; len[2*LW +: LW] = 8'd0; end
            tick();
            n_cmp++;
            if (b < 4 && (grant !== 6'h04 || done !== 1'b0)) begin
                n_bad++;
                $display("FAIL lock_beat%0d got grant=%h done=%b want 04/0", b, grant, done);
            end else if (b == 4 && (grant !== 6'h00 || done !== 1'b1 || active !== 1'b0)) begin
                n_bad++;
                $display("FAIL lock_done got grant=%h done=%b act=%b want 00/1/0", grant, done, active);
            end
        end
        request = '0;
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_done_pulse got done=%b want 0", done);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        do_reset();
        request = 6'h3F; len = '0; beat = 1'b1;
        for (int i = 0; i < 7; i++) begin
            want = '0;
            want[i % N] = 1'b1;
            tick();
            n_cmp++;
            if (grant !== want || select !== 3'(i % N)) begin
                n_bad++;
                $display("FAIL fair_grant%0d got grant=%h sel=%0d want %h", i, grant, select, want);
            end
            tick();
            n_cmp++;
            if (grant !== '0 || done !== 1'b1) begin
                n_bad++;
                $display("FAIL fair_bubble%0d got grant=%h done=%b want 00/1", i, grant, done);
            end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        request = 6'h02; len[1*LW +: LW] = 8'd7; beat = 1'b0;
        tick();
        request = 6'h06;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_cmp++;
            if (c < 4 && (grant !== 6'h02 || timeout !== 1'b0)) begin
                n_bad++;
                $display("FAIL wd_hold%0d got grant=%h to=%b want 02/0", c, grant, timeout);
            end else if (c == 4 && (grant !== 6'h00 || timeout !== 1'b1 || done !== 1'b0)) begin
                n_bad++;
                $display("FAIL wd_release got grant=%h to=%b done=%b want 00/1/0", grant, timeout, done);
            end
        end
        tick();
        n_cmp++;
        if (grant !== 6'h04 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL wd_next_winner got grant=%h to=%b want 04/0", grant, timeout);
        end
    endtask

    task automatic test_coincidence();
        do_reset();
        request = 6'h01; len[0 +: LW] = 8'd1; beat = 1'b0;
        tick();
        request = '0;
        beat = 1'b1; tick();
        beat = 1'b0; tick(); tick(); tick();
        n_cmp++;
        if (grant !== 6'h01 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL coin_hold got grant=%h to=%b want 01/0", grant, timeout);
        end
        beat = 1'b1; tick();
        n_cmp++;
        if (done !== 1'b1 || timeout !== 1'b0 || grant !== '0) begin
            n_bad++;
            $display("FAIL coin_done got done=%b to=%b grant=%h want 1/0/00", done, timeout, grant);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        request = 6'h08; len[3*LW +: LW] = 8'd4; beat = 1'b0;
        tick();
        beat = 1'b1; tick();
        rst = 1'b0; tick();
        n_cmp++;
        if (grant !== '0 || active !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_clear got grant=%h act=%b done=%b to=%b want 0", grant, active, done, timeout);
        end
        rst = 1'b1; request = 6'h3F; beat = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 6'h01) begin
            n_bad++;
            $display("FAIL midrst_pointer got grant=%h want 01", grant);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_g;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst     = ($urandom_range(0, 99) != 0);
            request = N'($urandom);
            beat    = ($urandom_range(0, 9) < 7);
            for (int p = 0; p < N; p++) len[p*LW +: LW] = LW'($urandom_range(0, 5));
            tick();
            exp_g = '0;
            if (m_owner >= 0) exp_g[m_owner] = 1'b1;
            n_cmp++;
            if (grant !== exp_g || select !== 3'((m_owner >= 0) ? m_owner : 0) ||
                active !== (m_owner >= 0) || done !== m_done || timeout !== m_to) begin
                n_bad++;
                $display("FAIL rand_c%0d got g=%h s=%0d a=%b d=%b t=%b want g=%h own=%0d d=%b t=%b",
                         c, grant, select, active, done, timeout, exp_g, m_owner, m_done, m_to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst_lock();
        test_fairness();
        test_watchdog();
        test_coincidence();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
